// File: rtl/zrb_sd_pkg.sv
// Shared constants and types for the SD-card SPI-mode init sequencer.
// Command framing data, state encoding and error codes live here.
package zrb_sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POWER_ON,
        ST_SEND_CMD,
        ST_POLL_R1,
        ST_READ_TAIL,
        ST_CHECK,
        ST_GAP,
        ST_READY,
        ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        CMD_0,
        CMD_8,
        CMD_55,
        CMD_41,
        CMD_58
    } cmd_e;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_TIMEOUT = 4'd1;
    localparam logic [3:0] ERR_R1      = 4'd2;
    localparam logic [3:0] ERR_ECHO    = 4'd3;
    localparam logic [3:0] ERR_RETRY   = 4'd4;

    localparam logic [5:0] IDX_CMD0   = 6'd0;
    localparam logic [5:0] IDX_CMD8   = 6'd8;
    localparam logic [5:0] IDX_CMD55  = 6'd55;
    localparam logic [5:0] IDX_ACMD41 = 6'd41;
    localparam logic [5:0] IDX_CMD58  = 6'd58;

    localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;

    localparam logic [7:0] CRC_CMD0  = 8'h95;
    localparam logic [7:0] CRC_CMD8  = 8'h87;
    localparam logic [7:0] CRC_DUMMY = 8'h01;

    function automatic logic [5:0] cmd_index(input cmd_e c);
        case (c)
            CMD_0:   return IDX_CMD0;
            CMD_8:   return IDX_CMD8;
            CMD_55:  return IDX_CMD55;
            CMD_41:  return IDX_ACMD41;
            CMD_58:  return IDX_CMD58;
            default: return IDX_CMD0;
        endcase
    endfunction

    function automatic logic [31:0] cmd_arg(input cmd_e c);
        case (c)
            CMD_8:   return ARG_CMD8;
            CMD_41:  return ARG_ACMD41;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] cmd_crc(input cmd_e c);
        case (c)
            CMD_0:   return CRC_CMD0;
            CMD_8:   return CRC_CMD8;
            default: return CRC_DUMMY;
        endcase
    endfunction

endpackage

// File: rtl/zrb_sd_cmd_frame.sv
// Registered byte mux: picks the next SPI byte of a 6-byte command frame,
// or the 0xFF idle byte whenever no command frame is being sent.
module zrb_sd_cmd_frame
    import zrb_sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  cmd_e       i_cmd,
    input  logic [2:0] i_idx,
    output logic [7:0] o_tx
);

    logic [31:0] w_arg;
    logic [7:0]  w_byte;
    logic [7:0]  r_tx;

    always_comb begin
        w_arg  = cmd_arg(i_cmd);
        w_byte = IDLE_BYTE;
        if (i_en) begin
            case (i_idx)
                3'd0:    w_byte = {2'b01, cmd_index(i_cmd)};
                3'd1:    w_byte = w_arg[31:24];
                3'd2:    w_byte = w_arg[23:16];
                3'd3:    w_byte = w_arg[15:8];
                3'd4:    w_byte = w_arg[7:0];
                3'd5:    w_byte = cmd_crc(i_cmd);
                default: w_byte = IDLE_BYTE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tx <= IDLE_BYTE;
        else       r_tx <= w_byte;
    end

    assign o_tx = r_tx;

endmodule

// File: rtl/zrb_sd_init_ctrl.sv
// SD-card SPI-mode init sequencer: power-on clocks, CMD0, CMD8,
// CMD55/ACMD41 loop, CMD58; one byte outstanding on the engine at a time.
module zrb_sd_init_ctrl
    import zrb_sd_pkg::*;
#(
    parameter int POWER_ON_BYTES = 10,
    parameter int RESP_POLL_MAX  = 8,
    parameter int ACMD41_RETRIES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       xfer_start,
    output logic [7:0] xfer_tx,
    input  logic       xfer_done,
    input  logic [7:0] xfer_rx,
    output logic       ss,
    output logic       low_full_speed,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [3:0] err_code,
    output logic [5:0] err_cmd,
    output logic       sdhc
);

    localparam logic [7:0] PON_LAST  = 8'(POWER_ON_BYTES - 1);
    localparam logic [7:0] POLL_LAST = 8'(RESP_POLL_MAX - 1);
    localparam logic [7:0] RETRY_MAX = 8'(ACMD41_RETRIES);

    state_e      r_state, w_state;
    cmd_e        r_cmd, w_cmd;
    logic [7:0]  r_cnt, w_cnt;
    logic [7:0]  r_r1, w_r1;
    logic [31:0] r_tail, w_tail;
    logic [7:0]  r_retry, w_retry;
    logic [3:0]  r_code, w_code;
    logic [5:0]  r_ecmd, w_ecmd;
    logic        r_sdhc, w_sdhc;
    logic        r_wait;
    logic        r_xs;
    logic [3:0]  w_fail;
    logic        w_done;
    logic        w_issue;

    // Done only counts while a byte is outstanding; stale pulses are dropped.
    assign w_done  = xfer_done && r_wait;
    assign w_issue = !r_wait && (r_state inside
        {ST_POWER_ON, ST_SEND_CMD, ST_POLL_R1, ST_READ_TAIL, ST_GAP});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_0;
            r_cnt   <= 8'd0;
            r_r1    <= 8'hFF;
            r_tail  <= 32'd0;
            r_retry <= 8'd0;
            r_code  <= ERR_NONE;
            r_ecmd  <= 6'd0;
            r_sdhc  <= 1'b0;
            r_wait  <= 1'b0;
            r_xs    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cmd   <= w_cmd;
            r_cnt   <= w_cnt;
            r_r1    <= w_r1;
            r_tail  <= w_tail;
            r_retry <= w_retry;
            r_code  <= w_code;
            r_ecmd  <= w_ecmd;
            r_sdhc  <= w_sdhc;
            r_xs    <= w_issue;
            r_wait  <= w_issue || (r_wait && !xfer_done);
        end
    end

    always_comb begin
        w_state = r_state;
        w_cmd   = r_cmd;
        w_cnt   = r_cnt;
        w_r1    = r_r1;
        w_tail  = r_tail;
        w_retry = r_retry;
        w_code  = r_code;
        w_ecmd  = r_ecmd;
        w_sdhc  = r_sdhc;
        w_fail  = ERR_NONE;
        unique case (r_state)
            ST_IDLE, ST_READY, ST_ERROR: begin
                if (start) begin
                    w_state = ST_POWER_ON;
                    w_cmd   = CMD_0;
                    w_cnt   = 8'd0;
                    w_retry = 8'd0;
                    w_code  = ERR_NONE;
                    w_ecmd  = 6'd0;
                    w_sdhc  = 1'b0;
                end
            end
            ST_POWER_ON: begin
                if (w_done) begin
                    w_cnt = r_cnt + 8'd1;
                    if (r_cnt == PON_LAST) begin
                        w_state = ST_SEND_CMD;
                        w_cnt   = 8'd0;
                    end
                end
            end
            ST_SEND_CMD: begin
                if (w_done) begin
                    w_cnt = r_cnt + 8'd1;
                    if (r_cnt == 8'd5) begin
                        w_state = ST_POLL_R1;
                        w_cnt   = 8'd0;
                    end
                end
            end
            ST_POLL_R1: begin
                if (w_done) begin
                    w_cnt = r_cnt + 8'd1;
                    if (!xfer_rx[7]) begin
                        w_r1    = xfer_rx;
                        w_cnt   = 8'd0;
                        w_state = (r_cmd == CMD_8 || r_cmd == CMD_58)
                                ? ST_READ_TAIL : ST_CHECK;
                    end else if (r_cnt == POLL_LAST) begin
                        w_fail = ERR_TIMEOUT;
                    end
                end
            end
            ST_READ_TAIL: begin
                if (w_done) begin
                    w_tail = (r_tail << 8) | {24'd0, xfer_rx};
                    w_cnt  = r_cnt + 8'd1;
                    if (r_cnt == 8'd3) w_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state = ST_GAP;
                case (r_cmd)
                    CMD_0: begin
                        if (r_r1 == 8'h01) w_cmd = CMD_8;
                        else               w_fail = ERR_R1;
                    end
                    CMD_8: begin
                        if (r_r1 != 8'h01)                w_fail = ERR_R1;
                        else if (r_tail[11:0] != 12'h1AA) w_fail = ERR_ECHO;
                        else                              w_cmd = CMD_55;
                    end
                    CMD_55: begin
                        if (r_r1 == 8'h00 || r_r1 == 8'h01) w_cmd = CMD_41;
                        else                                w_fail = ERR_R1;
                    end
                    CMD_41: begin
                        if (r_r1 == 8'h00) begin
                            w_cmd = CMD_58;
                        end else if (r_r1 == 8'h01) begin
                            w_retry = r_retry + 8'd1;
                            if (w_retry == RETRY_MAX) w_fail = ERR_RETRY;
                            else                      w_cmd = CMD_55;
                        end else begin
                            w_fail = ERR_R1;
                        end
                    end
                    CMD_58: begin
                        if (r_r1 == 8'h00) begin
                            w_state = ST_READY;
                            w_sdhc  = r_tail[30];
                        end else begin
                            w_fail = ERR_R1;
                        end
                    end
                    default: w_fail = ERR_R1;
                endcase
            end
            ST_GAP: begin
                if (w_done) begin
                    w_state = ST_SEND_CMD;
                    w_cnt   = 8'd0;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        if (w_fail != ERR_NONE) begin
            w_state = ST_ERROR;
            w_code  = w_fail;
            w_ecmd  = cmd_index(r_cmd);
        end
    end

    zrb_sd_cmd_frame u_frame (
        .clk   (clk),
        .reset (reset),
        .i_en  (r_state == ST_SEND_CMD),
        .i_cmd (r_cmd),
        .i_idx (r_cnt[2:0]),
        .o_tx  (xfer_tx)
    );

    assign xfer_start     = r_xs;
    assign ss             = !(r_state inside
        {ST_SEND_CMD, ST_POLL_R1, ST_READ_TAIL, ST_CHECK});
    assign busy           = !(r_state inside {ST_IDLE, ST_READY, ST_ERROR});
    assign init_done      = (r_state == ST_READY);
    assign init_err       = (r_state == ST_ERROR);
    assign low_full_speed = (r_state == ST_READY);
    assign err_code       = r_code;
    assign err_cmd        = r_ecmd;
    assign sdhc           = r_sdhc;

endmodule

// File: tb/tb_zrb_sd_init_ctrl.sv
// Directed bench for zrb_sd_init_ctrl with a byte-engine plus SD-card
// response model; expected values are hand-computed byte/command counts.
module tb_zrb_sd_init_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       xfer_start;
    logic [7:0] xfer_tx;
    logic       xfer_done = 1'b0;
    logic [7:0] xfer_rx = 8'hFF;
    logic       ss;
    logic       low_full_speed;
    logic       busy;
    logic       init_done;
    logic       init_err;
    logic [3:0] err_code;
    logic [5:0] err_cmd;
    logic       sdhc;

    always #5 clk = ~clk;

    zrb_sd_init_ctrl #(
        .POWER_ON_BYTES (10),
        .RESP_POLL_MAX  (8),
        .ACMD41_RETRIES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .xfer_start     (xfer_start),
        .xfer_tx        (xfer_tx),
        .xfer_done      (xfer_done),
        .xfer_rx        (xfer_rx),
        .ss             (ss),
        .low_full_speed (low_full_speed),
        .busy           (busy),
        .init_done      (init_done),
        .init_err       (init_err),
        .err_code       (err_code),
        .err_cmd        (err_cmd),
        .sdhc           (sdhc)
    );

    int checks = 0;
    int failures = 0;

    // Written only by the initial block
    int mode = 0;
    int epoch = 0;
    int inj_req = 0;

    // Written only by the engine/card model
    int inj_ack = 0;
    int cd = 0;
    int fcnt = 0;
    int nstart = 0;
    int n55 = 0;
    int n41 = 0;
    int a41_loc = 0;
    int card_ep = 0;
    int hi_run = 0;
    int first_run = -1;
    int run_ep = 0;
    int ovl = 0;
    int stab = 0;
    logic [5:0] fidx = 6'd63;
    logic [7:0] rec_tx = 8'hFF;
    logic [7:0] pend_rx = 8'hFF;
    logic [7:0] q[$];

    task automatic build(input logic [5:0] idx);
        case (idx)
            6'd0: begin
                if (mode == 4) begin
                    q.push_back(8'hFF);
                    q.push_back(8'hFF);
                end
                if (mode != 1) q.push_back(8'h01);
            end
            6'd8: begin
                q.push_back(8'h01);
                q.push_back(8'h00);
                q.push_back(8'h00);
                q.push_back(8'h01);
                q.push_back(mode == 2 ? 8'hAB : 8'hAA);
            end
            6'd55: q.push_back(8'h01);
            6'd41: begin
                a41_loc++;
                q.push_back((mode == 3 || a41_loc < 3) ? 8'h01 : 8'h00);
            end
            6'd58: begin
                q.push_back(8'h00);
                q.push_back(8'hC0);
                q.push_back(8'hFF);
                q.push_back(8'h80);
                q.push_back(8'h00);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        xfer_done = 1'b0;
        if (reset) begin
            cd = 0;
            fcnt = 0;
            q.delete();
            hi_run = 0;
            pend_rx = 8'hFF;
        end else begin
            if (cd > 0 && xfer_tx !== rec_tx) stab++;
            if (xfer_start && cd > 0) ovl++;
            if (inj_req != inj_ack) begin
                inj_ack = inj_req;
                xfer_done = 1'b1;
                xfer_rx = 8'h01;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    xfer_done = 1'b1;
                    xfer_rx = pend_rx;
                end
            end else if (xfer_start) begin
                nstart++;
                rec_tx = xfer_tx;
                cd = 3;
                pend_rx = 8'hFF;
                if (q.size() > 0) pend_rx = q.pop_front();
                if (ss) begin
                    hi_run++;
                end else begin
                    if (run_ep != epoch) begin
                        run_ep = epoch;
                        first_run = hi_run;
                    end
                    hi_run = 0;
                    if (fcnt == 0 && xfer_tx[7:6] == 2'b01) begin
                        fidx = xfer_tx[5:0];
                        fcnt = 1;
                        if (card_ep != epoch) begin
                            card_ep = epoch;
                            a41_loc = 0;
                        end
                        if (fidx == 6'd55) n55++;
                        if (fidx == 6'd41) n41++;
                    end else if (fcnt > 0) begin
                        fcnt++;
                        if (fcnt == 6) begin
                            fcnt = 0;
                            build(fidx);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int m);
        mode = m;
        epoch++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 5000), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_xs"},   32'(xfer_start), 32'd0);
        check({tag, "_tx"},   32'(xfer_tx), 32'hFF);
        check({tag, "_ss"},   32'(ss), 32'd1);
        check({tag, "_lfs"},  32'(low_full_speed), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(init_done), 32'd0);
        check({tag, "_err"},  32'(init_err), 32'd0);
        check({tag, "_code"}, 32'(err_code), 32'd0);
        check({tag, "_cmd"},  32'(err_cmd), 32'd0);
        check({tag, "_sdhc"}, 32'(sdhc), 32'd0);
    endtask

    initial begin
        int s_n;
        int s_41;
        int s_55;
        int n;
        logic seen;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Normal card: ACMD41 busy twice, SDHC
        s_n = nstart;
        s_41 = n41;
        pulse_start(0);
        wait_idle("s1_timeout");
        check("s1_done", 32'(init_done), 32'd1);
        check("s1_err", 32'(init_err), 32'd0);
        check("s1_sdhc", 32'(sdhc), 32'd1);
        check("s1_lfs", 32'(low_full_speed), 32'd1);
        check("s1_ss", 32'(ss), 32'd1);
        check("s1_pon_bytes", 32'(first_run), 32'd10);
        check("s1_acmd41", 32'(n41 - s_41), 32'd3);
        check("s1_bytes", 32'(nstart - s_n), 32'd89);

        // No R1 after CMD0
        s_n = nstart;
        pulse_start(1);
        wait_idle("s2_timeout");
        check("s2_err", 32'(init_err), 32'd1);
        check("s2_done", 32'(init_done), 32'd0);
        check("s2_code", 32'(err_code), 32'd1);
        check("s2_cmd", 32'(err_cmd), 32'd0);
        check("s2_ss", 32'(ss), 32'd1);
        check("s2_lfs", 32'(low_full_speed), 32'd0);
        check("s2_bytes", 32'(nstart - s_n), 32'd24);

        // CMD8 echo mismatch
        s_n = nstart;
        pulse_start(2);
        wait_idle("s3_timeout");
        check("s3_err", 32'(init_err), 32'd1);
        check("s3_code", 32'(err_code), 32'd3);
        check("s3_cmd", 32'(err_cmd), 32'd8);
        check("s3_sdhc", 32'(sdhc), 32'd0);
        check("s3_bytes", 32'(nstart - s_n), 32'd29);

        // ACMD41 never leaves idle
        s_n = nstart;
        s_41 = n41;
        s_55 = n55;
        pulse_start(3);
        wait_idle("s4_timeout");
        check("s4_err", 32'(init_err), 32'd1);
        check("s4_code", 32'(err_code), 32'd4);
        check("s4_cmd", 32'(err_cmd), 32'd41);
        check("s4_acmd41", 32'(n41 - s_41), 32'd4);
        check("s4_cmd55", 32'(n55 - s_55), 32'd4);
        check("s4_bytes", 32'(nstart - s_n), 32'd93);

        // Reset during CMD8 argument bytes, then a stale done
        pulse_start(0);
        n = 0;
        while (!(fidx == 6'd8 && fcnt >= 2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("s5_reach_cmd8", 32'(n < 2000), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        s_n = nstart;
        inj_req++;
        repeat (20) @(negedge clk);
        check("s5_no_start", 32'(nstart - s_n), 32'd0);
        check_reset_vals("s5");
        s_n = nstart;
        pulse_start(0);
        wait_idle("s5b_timeout");
        check("s5b_done", 32'(init_done), 32'd1);
        check("s5b_pon_bytes", 32'(first_run), 32'd10);
        check("s5b_bytes", 32'(nstart - s_n), 32'd89);

        // Delayed R1 on CMD0, start pulsed together with a mid-sequence done
        s_n = nstart;
        s_41 = n41;
        pulse_start(4);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            #1;
            if (xfer_done && fidx == 6'd8) seen = 1'b1;
            n++;
        end
        check("s6_seen_done", 32'(seen), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("s6_timeout");
        check("s6_done", 32'(init_done), 32'd1);
        check("s6_sdhc", 32'(sdhc), 32'd1);
        check("s6_pon_bytes", 32'(first_run), 32'd10);
        check("s6_acmd41", 32'(n41 - s_41), 32'd3);
        check("s6_bytes", 32'(nstart - s_n), 32'd91);

        check("overlap_starts", 32'(ovl), 32'd0);
        check("tx_unstable", 32'(stab), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
